// File: rtl/uart_cmd_initiator.sv
// uart_cmd_initiator: issues one Hamming(7,4)-protected command byte over the
// UART link and waits for the remote end to echo it back. A bad echo, a parity
// error or a silent line costs one attempt; after MAX_RETRY retransmissions the
// transaction is reported as failed.
module uart_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 4800,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,          // asynchronous, active low
  input  logic [3:0] i_cmd,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic [1:0] o_attempts,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_busy,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_rx_parity_error
);

  // Timeout counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits suffice.
  localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_ECHO,
    S_DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic [1:0]    r_retry, w_retry_next;
  logic [TW-1:0] r_tmo, w_tmo_next;
  logic          r_busy_seen, w_busy_seen_next;
  logic          r_ack_ok, w_ack_ok_next;
  logic [1:0]    r_attempts, w_attempts_next;

  logic [2:0]    w_par;
  logic [7:0]    w_enc;
  logic          w_echo_ok;

  // Hamming(7,4): bit i of the byte is code position i+1; parity bits sit at
  // positions 1, 2 and 4, data bits at 3, 5, 6 and 7, bit 7 is always zero.
  assign w_par[0] = i_cmd[0] ^ i_cmd[1] ^ i_cmd[3];
  assign w_par[1] = i_cmd[0] ^ i_cmd[2] ^ i_cmd[3];
  assign w_par[2] = i_cmd[1] ^ i_cmd[2] ^ i_cmd[3];
  assign w_enc    = {1'b0, i_cmd[3], i_cmd[2], i_cmd[1], w_par[2], i_cmd[0], w_par[1], w_par[0]};

  // A clean echo must match the byte held for this transaction.
  assign w_echo_ok = i_rx_done && !i_rx_parity_error && (i_rx_data == r_tx_data);

  assign o_tx_data  = r_tx_data;
  assign o_ack_ok   = r_ack_ok;
  assign o_attempts = r_attempts;

  // State and datapath registers; reset aborts any transaction at once.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_tx_data   <= 8'h00;
      r_retry     <= 2'd0;
      r_tmo       <= '0;
      r_busy_seen <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_attempts  <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_tx_data   <= w_tx_data_next;
      r_retry     <= w_retry_next;
      r_tmo       <= w_tmo_next;
      r_busy_seen <= w_busy_seen_next;
      r_ack_ok    <= w_ack_ok_next;
      r_attempts  <= w_attempts_next;
    end
  end

  // Next-state logic and the combinational handshake outputs.
  always_comb begin
    w_state_next     = r_state;
    w_tx_data_next   = r_tx_data;
    w_retry_next     = r_retry;
    w_tmo_next       = r_tmo;
    w_busy_seen_next = r_busy_seen;
    w_ack_ok_next    = r_ack_ok;
    w_attempts_next  = r_attempts;
    o_cmd_ready      = 1'b0;
    o_tx_start       = 1'b0;
    o_done           = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_tx_data_next  = w_enc;
          w_retry_next    = 2'd0;
          w_ack_ok_next   = 1'b0;
          w_attempts_next = 2'd0;
          w_state_next    = S_SEND;
        end
      end

      S_SEND: begin
        if (!i_tx_busy) begin
          o_tx_start       = 1'b1;
          w_busy_seen_next = 1'b0;
          w_state_next     = S_WAIT_TX;
        end
      end

      // The transmitter must be seen busy first, otherwise the start pulse
      // could be mistaken for an already finished frame.
      S_WAIT_TX: begin
        if (i_tx_busy) begin
          w_busy_seen_next = 1'b1;
        end else if (r_busy_seen) begin
          w_tmo_next   = '0;
          w_state_next = S_WAIT_ECHO;
        end
      end

      // A received byte takes priority over a timeout landing in the same cycle.
      S_WAIT_ECHO: begin
        w_tmo_next = r_tmo + TW'(1);
        if (w_echo_ok) begin
          w_ack_ok_next   = 1'b1;
          w_attempts_next = r_retry;
          w_state_next    = S_DONE;
        end else if (i_rx_done || (r_tmo == TMO_LAST)) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_next = r_retry + 2'd1;
            w_state_next = S_SEND;
          end else begin
            w_ack_ok_next   = 1'b0;
            w_attempts_next = r_retry;
            w_state_next    = S_DONE;
          end
        end
      end

      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Bench for uart_cmd_initiator: a simple transmitter/remote model plays back a
// per-attempt echo script, and an outcome model predicts the result from it.
module tb_uart_cmd_initiator;
  localparam int TMO    = 4800;
  localparam int MAXR   = 3;
  localparam int TX_CYC = 20;     // shortened frame time of the modelled uart_tx

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmd = 4'h0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, done, ack_ok, tx_start;
  logic [1:0] attempts;
  logic [7:0] tx_data;
  logic       model_busy = 1'b0, ext_busy = 1'b0;
  logic       tx_busy;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0, rx_par = 1'b0;

  assign tx_busy = model_busy | ext_busy;

  // echo script for attempts 0..MAXR of the current transaction
  logic [7:0] beh_byte [4];
  bit         beh_par [4];
  bit         beh_silent [4];
  int         beh_delay [4];

  int         n_checks = 0, n_errors = 0;
  int         cyc = 0, rx_cyc = 0, done_cyc = 0, done_cnt = 0;
  int         base = 0;
  int         silent_budget = 4;
  logic [7:0] start_bytes [$];
  int         start_cycs [$];

  uart_cmd_initiator #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_cmd(cmd), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready), .o_done(done), .o_ack_ok(ack_ok), .o_attempts(attempts),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .i_rx_parity_error(rx_par)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (rx_done) rx_cyc = cyc;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Generic Hamming(7,4): data at code positions 3,5,6,7; parity at 1,2,4
  // covers every position whose index has that parity bit set.
  function automatic logic [7:0] ref_enc(input logic [3:0] c);
    logic [7:0] b;
    int dpos [4];
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
    b = 8'h00;
    for (int k = 0; k < 4; k++) b[dpos[k]-1] = c[k];
    for (int p = 1; p <= 4; p = p * 2)
      for (int j = 1; j <= 7; j++)
        if (((j & p) != 0) && (j != p)) b[p-1] = b[p-1] ^ b[j-1];
    return b;
  endfunction

  // First attempt whose echo is clean and arrives in time wins.
  function automatic void ref_outcome(input logic [7:0] e, output bit ack, output int att);
    ack = 1'b0;
    att = MAXR;
    for (int i = 0; i <= MAXR; i++) begin
      if (!ack && !beh_silent[i] && beh_delay[i] < TMO && !beh_par[i] && beh_byte[i] == e) begin
        ack = 1'b1;
        att = i;
      end
    end
  endfunction

  task automatic set_beh(input int i, input logic [7:0] b, input bit par, input bit sil, input int d);
    beh_byte[i] = b; beh_par[i] = par; beh_silent[i] = sil; beh_delay[i] = d;
  endtask

  // Transmitter + remote echo model: busy for TX_CYC cycles after a start,
  // then (unless silent) echo after beh_delay cycles of the wait window.
  initial begin : remote
    int idx;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        idx = start_bytes.size() - base;
        start_bytes.push_back(tx_data);
        start_cycs.push_back(cyc);
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (TX_CYC) @(posedge clk);
        #1 model_busy = 1'b0;
        @(posedge clk);
        if (idx >= 0 && idx <= MAXR && !beh_silent[idx]) begin
          repeat (beh_delay[idx]) @(posedge clk);
          #1 rx_data = beh_byte[idx]; rx_par = beh_par[idx]; rx_done = 1'b1;
          @(posedge clk); #1 rx_done = 1'b0; rx_par = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    check("ready_wait", 32'(got), 32'd1);
  endtask

  task automatic do_txn(input logic [3:0] c, input int hold_busy, input bit chk_gap);
    logic [7:0] e;
    bit exp_ack, got;
    int exp_att, n, seen;
    e = ref_enc(c);
    ref_outcome(e, exp_ack, exp_att);
    base = start_bytes.size();
    wait_ready();
    @(posedge clk); #1 cmd = c; cmd_valid = 1'b1;
    if (hold_busy > 0) ext_busy = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("tx_data", 32'(tx_data), 32'(e));
    check("ready_low", 32'(cmd_ready), 32'd0);
    if (hold_busy > 0) begin
      seen = 0;
      for (int i = 0; i < hold_busy; i++) begin
        if (tx_start) seen++;
        @(negedge clk);
      end
      check("start_in_busy", 32'(seen), 32'd0);
      @(posedge clk); #1 ext_busy = 1'b0;
      @(negedge clk);
      check("start_after_busy", 32'(tx_start), 32'd1);
    end else begin
      check("start_n1", 32'(tx_start), 32'd1);
    end
    got = 1'b0;
    for (int i = 0; i < 30000 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("ack_ok", 32'(ack_ok), 32'(exp_ack));
      check("attempts", 32'(attempts), 32'(exp_att));
      check("ready_in_done", 32'(cmd_ready), 32'd0);
      n = start_bytes.size() - base;
      check("n_starts", 32'(n), 32'(exp_att + 1));
      for (int i = 0; i < n; i++) check("start_byte", 32'(start_bytes[base+i]), 32'(e));
      if (exp_ack) check("done_latency", 32'(done_cyc - rx_cyc), 32'd1);
      if (chk_gap)
        for (int i = 1; i < n; i++)
          check("retry_gap", 32'(start_cycs[base+i] - start_cycs[base+i-1]), 32'(TX_CYC + TMO + 2));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("ready_back", 32'(cmd_ready), 32'd1);
    end
    $display("txn cmd=%h enc=%h ack=%0d att=%0d starts=%0d", c, e, ack_ok, attempts,
             start_bytes.size() - base);
  endtask

  task automatic all_good(input logic [3:0] c, input int d);
    for (int i = 0; i <= MAXR; i++) set_beh(i, ref_enc(c), 1'b0, 1'b0, d);
  endtask

  task automatic rand_beh(input logic [3:0] c);
    logic [7:0] e;
    int r;
    e = ref_enc(c);
    for (int i = 0; i <= MAXR; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 6) set_beh(i, e ^ (8'h01 << $urandom_range(0, 7)), 1'b0, 1'b0, int'($urandom_range(0, 300)));
      else if (r == 7) set_beh(i, e, 1'b1, 1'b0, int'($urandom_range(0, 300)));
      else if (r == 8 && silent_budget > 0) begin
        silent_budget--;
        set_beh(i, e, 1'b0, 1'b1, 0);
      end else if (r == 9) set_beh(i, ~e, 1'b0, 1'b0, int'($urandom_range(0, 300)));
      else set_beh(i, e, 1'b0, 1'b0, int'($urandom_range(0, 300)));
    end
  endtask

  initial begin : main
    int dcnt;
    logic [3:0] c;
    #2;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack", 32'(ack_ok), 32'd0);
    check("rst_att", 32'(attempts), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    // success path: 12 us at 48 MHz
    all_good(4'h6, 576);
    do_txn(4'h6, 0, 1'b0);

    // encoding sweep
    for (int k = 0; k < 16; k++) begin
      c = 4'(k);
      all_good(c, int'($urandom_range(0, 40)));
      do_txn(c, 0, 1'b0);
    end

    // total silence
    for (int i = 0; i <= MAXR; i++) set_beh(i, 8'h00, 1'b0, 1'b1, 0);
    do_txn(4'h6, 0, 1'b1);

    // bad echo, parity error, then good
    set_beh(0, 8'h34, 1'b0, 1'b0, 30);
    set_beh(1, 8'h33, 1'b1, 1'b0, 30);
    set_beh(2, 8'h33, 1'b0, 1'b0, 30);
    set_beh(3, 8'h33, 1'b0, 1'b0, 30);
    do_txn(4'h6, 0, 1'b0);

    // echo on the timeout cycle, transmitter busy at SEND
    all_good(4'hD, TMO - 1);
    do_txn(4'hD, 50, 1'b0);

    // reset during the echo wait, with an extra request while busy
    for (int i = 0; i <= MAXR; i++) set_beh(i, 8'h00, 1'b0, 1'b1, 0);
    base = start_bytes.size();
    wait_ready();
    @(posedge clk); #1 cmd = 4'h9; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd = 4'h2;
    repeat (5) @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("ignored_req", 32'(tx_data), 32'(ref_enc(4'h9)));
    repeat (TX_CYC + 20) @(negedge clk);
    dcnt = done_cnt;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ack", 32'(ack_ok), 32'd0);
    check("abort_att", 32'(attempts), 32'd0);
    check("abort_txdata", 32'(tx_data), 32'd0);
    check("abort_start", 32'(tx_start), 32'd0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(dcnt));
    check("abort_starts", 32'(start_bytes.size() - base), 32'd1);
    $display("txn cmd=9 aborted by reset starts=%0d", start_bytes.size() - base);

    all_good(4'hA, 10);
    do_txn(4'hA, 0, 1'b0);

    // randomized transactions against the outcome model
    for (int k = 0; k < 10; k++) begin
      c = 4'($urandom_range(0, 15));
      rand_beh(c);
      do_txn(c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
